// File: rtl/fact_pkg.sv
// Shared definitions for the factorial bus master: register map, status bits, FSM states.
package fact_pkg;

  localparam logic [1:0] FACT_A_N      = 2'd0;
  localparam logic [1:0] FACT_A_GO     = 2'd1;
  localparam logic [1:0] FACT_A_STATUS = 2'd2;
  localparam logic [1:0] FACT_A_RESULT = 2'd3;

  localparam int unsigned DONE_BIT = 0;
  localparam int unsigned ERR_BIT  = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_N,
    WR_GO,
    WAIT,
    POLL,
    RD_RES,
    RESP
  } fact_state_e;

endpackage

// File: rtl/fact_master_if.sv
// Host request/response channels plus the register bus towards the factorial peripheral.
interface fact_master_if;

  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_n;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_err;
  logic        resp_timeout;
  logic        busy;
  logic [1:0]  bus_a;
  logic        bus_we;
  logic [3:0]  bus_wd;
  logic [31:0] bus_rd;

  modport master (
    input  req_valid, req_n, resp_ready, bus_rd,
    output req_ready, resp_valid, resp_result, resp_err, resp_timeout,
           busy, bus_a, bus_we, bus_wd
  );

  modport slave (
    output req_valid, req_n, resp_ready, bus_rd,
    input  req_ready, resp_valid, resp_result, resp_err, resp_timeout,
           busy, bus_a, bus_we, bus_wd
  );

endinterface

// File: rtl/fact_poll_timer.sv
// Settle/poll-gap down-counter and job timeout up-counter for fact_master.
module fact_poll_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wait_load,
  input  logic [15:0] wait_val,
  input  logic        wait_dec,
  input  logic        tmo_clr,
  input  logic        tmo_inc,
  output logic        wait_last,
  output logic        tmo_expired
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [15:0]   wait_cnt_q, wait_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // wait_last: the current wait cycle is the final one of the loaded count
  assign wait_last   = (wait_cnt_q <= 16'd1);
  assign tmo_expired = (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

  // Next-count logic for both counters
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    if (wait_load) begin
      wait_cnt_d = wait_val;
    end else if (wait_dec && (wait_cnt_q != 16'd0)) begin
      wait_cnt_d = wait_cnt_q - 16'd1;
    end
    if (tmo_clr) begin
      tmo_cnt_d = '0;
    end else if (tmo_inc && !tmo_expired) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

endmodule

// File: rtl/fact_master.sv
// Bus initiator for the factorial peripheral: write N, write GO, poll STATUS, read RESULT.
module fact_master
  import fact_pkg::*;
#(
  parameter int unsigned POLL_GAP    = 2,
  parameter int unsigned SETTLE      = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  fact_master_if.master m
);

  fact_state_e state_q, state_d;
  logic [3:0]  n_q, n_d;
  logic [31:0] resp_result_q, resp_result_d;
  logic        resp_err_q, resp_err_d;
  logic        resp_timeout_q, resp_timeout_d;
  logic        resp_valid_q, resp_valid_d;
  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;
  logic [1:0]  bus_a_q, bus_a_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_wd_q, bus_wd_d;

  logic        wait_load, wait_dec, tmo_clr, tmo_inc;
  logic [15:0] wait_val;
  logic        wait_last, tmo_expired;

  fact_poll_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .wait_load  (wait_load),
    .wait_val   (wait_val),
    .wait_dec   (wait_dec),
    .tmo_clr    (tmo_clr),
    .tmo_inc    (tmo_inc),
    .wait_last  (wait_last),
    .tmo_expired(tmo_expired)
  );

  // Next state, response capture, and registered outputs decoded from the next state
  // so each output register lines up with the state it belongs to.
  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    resp_result_d  = resp_result_q;
    resp_err_d     = resp_err_q;
    resp_timeout_d = resp_timeout_q;
    wait_load      = 1'b0;
    wait_val       = '0;
    wait_dec       = 1'b0;
    tmo_clr        = 1'b0;
    tmo_inc        = 1'b0;

    case (state_q)
      IDLE: begin
        if (m.req_valid) begin
          n_d     = m.req_n;
          state_d = WR_N;
        end
      end
      WR_N: state_d = WR_GO;
      WR_GO: begin
        tmo_clr   = 1'b1;
        wait_load = 1'b1;
        wait_val  = 16'(SETTLE);
        state_d   = WAIT;
      end
      WAIT: begin
        tmo_inc  = 1'b1;
        wait_dec = 1'b1;
        if (tmo_expired) begin
          resp_result_d  = '0;
          resp_err_d     = 1'b0;
          resp_timeout_d = 1'b1;
          state_d        = RESP;
        end else if (wait_last) begin
          state_d = POLL;
        end
      end
      POLL: begin
        tmo_inc = 1'b1;
        // A done/err observation beats a timeout expiring in the same cycle
        if (m.bus_rd[ERR_BIT]) begin
          resp_result_d  = '0;
          resp_err_d     = 1'b1;
          resp_timeout_d = 1'b0;
          state_d        = RESP;
        end else if (m.bus_rd[DONE_BIT]) begin
          state_d = RD_RES;
        end else if (tmo_expired) begin
          resp_result_d  = '0;
          resp_err_d     = 1'b0;
          resp_timeout_d = 1'b1;
          state_d        = RESP;
        end else if (POLL_GAP != 0) begin
          wait_load = 1'b1;
          wait_val  = 16'(POLL_GAP);
          state_d   = WAIT;
        end
      end
      RD_RES: begin
        resp_result_d  = m.bus_rd;
        resp_err_d     = 1'b0;
        resp_timeout_d = 1'b0;
        state_d        = RESP;
      end
      RESP: begin
        if (m.resp_ready) begin
          resp_result_d  = '0;
          resp_err_d     = 1'b0;
          resp_timeout_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    resp_valid_d = (state_d == RESP);
    bus_we_d     = (state_d == WR_N) || (state_d == WR_GO);
    case (state_d)
      WR_N:    begin bus_a_d = FACT_A_N;      bus_wd_d = n_d;     end
      WR_GO:   begin bus_a_d = FACT_A_GO;     bus_wd_d = 4'b0001; end
      POLL:    begin bus_a_d = FACT_A_STATUS; bus_wd_d = '0;      end
      RD_RES:  begin bus_a_d = FACT_A_RESULT; bus_wd_d = '0;      end
      default: begin bus_a_d = '0;            bus_wd_d = '0;      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      n_q            <= '0;
      resp_result_q  <= '0;
      resp_err_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_valid_q   <= 1'b0;
      req_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      bus_a_q        <= '0;
      bus_we_q       <= 1'b0;
      bus_wd_q       <= '0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      resp_result_q  <= resp_result_d;
      resp_err_q     <= resp_err_d;
      resp_timeout_q <= resp_timeout_d;
      resp_valid_q   <= resp_valid_d;
      req_ready_q    <= req_ready_d;
      busy_q         <= busy_d;
      bus_a_q        <= bus_a_d;
      bus_we_q       <= bus_we_d;
      bus_wd_q       <= bus_wd_d;
    end
  end

  assign m.req_ready    = req_ready_q;
  assign m.busy         = busy_q;
  assign m.resp_valid   = resp_valid_q;
  assign m.resp_result  = resp_result_q;
  assign m.resp_err     = resp_err_q;
  assign m.resp_timeout = resp_timeout_q;
  assign m.bus_a        = bus_a_q;
  assign m.bus_we       = bus_we_q;
  assign m.bus_wd       = bus_wd_q;

endmodule

// File: tb/tb_fact_master.sv
// Bench for fact_master: behavioural factorial peripheral, response scoreboard,
// and a second instance against a slave that never completes.
module tb_fact_master;

  localparam int unsigned PERIPH_LAT = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fact_master_if h1();
  fact_master_if h2();

  fact_master #(.POLL_GAP(2), .SETTLE(2), .TIMEOUT_CYC(1024)) u_dut (
    .clk(clk), .rst_n(rst_n), .m(h1.master)
  );
  fact_master #(.POLL_GAP(0), .SETTLE(2), .TIMEOUT_CYC(16)) u_tmo (
    .clk(clk), .rst_n(rst_n), .m(h2.master)
  );

  typedef struct { logic [31:0] res; logic err; logic tmo; } exp_t;
  typedef struct { logic [3:0] n; logic [31:0] res; logic err; } vec_t;

  exp_t        sb[$];
  logic [5:0]  wr_log[$];
  exp_t        mon_e;
  int unsigned cmp_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned rd3_cnt = 0;
  int unsigned rdy_viol = 0;
  int unsigned poll2_cnt = 0;
  int unsigned cyc = 0;
  int unsigned go_edge = 0;

  // Behavioural factorial peripheral on h1
  logic [3:0]  p_n = '0;
  logic        p_done = 1'b0, p_err = 1'b0, p_stale = 1'b0, p_run = 1'b0;
  logic [31:0] p_res = '0;
  int unsigned p_cnt = 0;

  function automatic logic [31:0] fact(input logic [3:0] n);
    logic [31:0] r = 32'd1;
    for (int unsigned i = 2; i <= 32'(n); i++) r = r * i;
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (h1.bus_we && h1.bus_a == 2'd0) p_n <= h1.bus_wd;
    if (h1.bus_we && h1.bus_a == 2'd1 && h1.bus_wd[0]) begin
      // done from the previous job lingers for one cycle after GO
      p_stale <= p_done;
      p_done  <= 1'b0;
      p_err   <= 1'b0;
      p_run   <= 1'b1;
      p_cnt   <= PERIPH_LAT;
    end else if (p_run) begin
      p_stale <= 1'b0;
      if (p_cnt == 0) begin
        p_run <= 1'b0;
        if (p_n > 4'd12) p_err <= 1'b1;
        else begin p_done <= 1'b1; p_res <= fact(p_n); end
      end else p_cnt <= p_cnt - 1;
    end
  end

  assign h1.bus_rd = (h1.bus_a == 2'd0) ? {28'd0, p_n} :
                     (h1.bus_a == 2'd2) ? {30'd0, p_err, p_done | p_stale} :
                     (h1.bus_a == 2'd3) ? p_res : 32'd0;
  assign h2.bus_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  // Bus/response monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (h1.bus_we) wr_log.push_back({h1.bus_a, h1.bus_wd});
    if (!h1.bus_we && h1.bus_a == 2'd3) rd3_cnt++;
    if (h1.busy && h1.req_ready) rdy_viol++;
    if (h2.bus_we && h2.bus_a == 2'd1) go_edge = cyc + 1;
    if (!h2.bus_we && h2.bus_a == 2'd2) poll2_cnt++;
    if (h1.resp_valid && h1.resp_ready) begin
      if (sb.size() == 0) begin
        cmp_cnt++; err_cnt++;
        $display("FAIL sb_unexpected: got result %0d with nothing expected", h1.resp_result);
      end else begin
        mon_e = sb.pop_front();
        check("resp_result", h1.resp_result, mon_e.res);
        check("resp_err", {31'd0, h1.resp_err}, {31'd0, mon_e.err});
        check("resp_timeout", {31'd0, h1.resp_timeout}, {31'd0, mon_e.tmo});
      end
    end
  end

  task automatic send1(input logic [3:0] n, input logic push, input exp_t e);
    logic got = 1'b0;
    if (push) sb.push_back(e);
    h1.req_n = n;
    h1.req_valid = 1'b1;
    for (int unsigned k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (h1.req_ready) got = 1'b1;
    end
    @(posedge clk); #1;
    h1.req_valid = 1'b0;
    check("req_accepted", {31'd0, got}, 32'd1);
    check("req_ready_low_in_job", {31'd0, h1.req_ready}, 32'd0);
    check("busy_in_job", {31'd0, h1.busy}, 32'd1);
  endtask

  task automatic wait_done(input string name);
    for (int unsigned k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      cmp_cnt++; err_cnt++;
      $display("FAIL %s: %0d responses outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  vec_t        vt[6];
  int unsigned hold_bad, we_cnt, lat;
  logic        seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    h1.req_valid = 1'b0; h1.req_n = '0; h1.resp_ready = 1'b1;
    h2.req_valid = 1'b0; h2.req_n = '0; h2.resp_ready = 1'b1;
    vt[0] = '{4'd5,  32'd120,     1'b0};
    vt[1] = '{4'd1,  32'd1,       1'b0};
    vt[2] = '{4'd7,  32'd5040,    1'b0};
    vt[3] = '{4'd10, 32'd3628800, 1'b0};
    vt[4] = '{4'd13, 32'd0,       1'b1};
    vt[5] = '{4'd15, 32'd0,       1'b1};

    #1 rst_n = 1'b0;
    #2;
    check("rst_req_ready", {31'd0, h1.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, h1.resp_valid}, 32'd0);
    check("rst_resp_result", h1.resp_result, 32'd0);
    check("rst_busy", {31'd0, h1.busy}, 32'd0);
    check("rst_bus_we", {31'd0, h1.bus_we}, 32'd0);
    check("rst_bus_a", {30'd0, h1.bus_a}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table-driven jobs: response, bus write trace and RESULT-read count per job
    for (int unsigned i = 0; i < 6; i++) begin
      wr_log.delete();
      rd3_cnt = 0;
      send1(vt[i].n, 1'b1, '{vt[i].res, vt[i].err, 1'b0});
      wait_done("vec_resp");
      check("wr_count", wr_log.size(), 32'd2);
      if (wr_log.size() >= 2) begin
        check("wr0_N", {26'd0, wr_log[0]}, {26'd0, 2'd0, vt[i].n});
        check("wr1_GO", {26'd0, wr_log[1]}, {26'd0, 2'd1, 4'd1});
      end
      check("result_reads", rd3_cnt, vt[i].err ? 32'd0 : 32'd1);
    end

    // Back-to-back jobs; second must not accept the first job's stale done
    send1(4'd0, 1'b1, '{32'd1, 1'b0, 1'b0});
    send1(4'd12, 1'b1, '{32'd479001600, 1'b0, 1'b0});
    wait_done("b2b_resp");

    // Response back-pressure
    h1.resp_ready = 1'b0;
    send1(4'd3, 1'b1, '{32'd6, 1'b0, 1'b0});
    seen = 1'b0;
    for (int unsigned k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = h1.resp_valid;
    end
    check("bp_valid_seen", {31'd0, seen}, 32'd1);
    hold_bad = 0; we_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (!h1.resp_valid || h1.resp_result !== 32'd6 || h1.resp_err || h1.resp_timeout) hold_bad++;
      if (h1.bus_we) we_cnt++;
    end
    check("bp_hold", hold_bad, 32'd0);
    check("bp_bus_quiet", we_cnt, 32'd0);
    check("bp_pending", sb.size(), 32'd1);
    @(posedge clk); #1;
    h1.resp_ready = 1'b1;
    wait_done("bp_resp");
    check("bp_idle_ready", {31'd0, h1.req_ready}, 32'd1);
    check("bp_idle_valid", {31'd0, h1.resp_valid}, 32'd0);

    // Timeout against a slave that never reports done (TIMEOUT_CYC=16, POLL_GAP=0)
    poll2_cnt = 0;
    h2.req_n = 4'd5;
    h2.req_valid = 1'b1;
    @(negedge clk);
    check("tmo_req_ready", {31'd0, h2.req_ready}, 32'd1);
    @(posedge clk); #1;
    h2.req_valid = 1'b0;
    seen = 1'b0;
    for (int unsigned k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = h2.resp_valid;
    end
    lat = cyc - go_edge;
    check("tmo_valid_seen", {31'd0, seen}, 32'd1);
    check("tmo_latency", lat, 32'd16);
    check("tmo_flag", {31'd0, h2.resp_timeout}, 32'd1);
    check("tmo_err", {31'd0, h2.resp_err}, 32'd0);
    check("tmo_result", h2.resp_result, 32'd0);
    check("tmo_polls", poll2_cnt, 32'd14);
    @(posedge clk); #1;

    // Asynchronous reset while polling, then a fresh job
    send1(4'd9, 1'b0, '{32'd0, 1'b0, 1'b0});
    seen = 1'b0;
    for (int unsigned k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = !h1.bus_we && h1.bus_a == 2'd2;
    end
    check("rst_poll_reached", {31'd0, seen}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req_ready", {31'd0, h1.req_ready}, 32'd1);
    check("arst_busy", {31'd0, h1.busy}, 32'd0);
    check("arst_bus_a", {30'd0, h1.bus_a}, 32'd0);
    check("arst_bus_we", {31'd0, h1.bus_we}, 32'd0);
    check("arst_bus_wd", {28'd0, h1.bus_wd}, 32'd0);
    check("arst_resp_valid", {31'd0, h1.resp_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send1(4'd4, 1'b1, '{32'd24, 1'b0, 1'b0});
    wait_done("post_rst_resp");

    check("ready_busy_exclusive", rdy_viol, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fact_master.md
Name: fact_master

Overview:
- Bus initiator that drives the factorial accelerator's 4-register memory-mapped slave port.
- Accepts a job (4-bit n) on a valid/ready request channel. Issues the bus sequence: write N, write GO, poll STATUS, read RESULT.
- Returns the 32-bit result, or an error/timeout indication, on a valid/ready response channel.
- Sits between a host (core-side sequencer or test harness) and the factorial peripheral. It is the other end of that register interface.

Parameters:
- POLL_GAP, 2, idle cycles between consecutive STATUS reads (≥0).
- SETTLE, 2, cycles to wait after the GO write before the first STATUS read (≥2).
- TIMEOUT_CYC, 1024, maximum cycles from the GO write to observed done/err before the job is abandoned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  job request valid.
- req_ready  out  1  master idle, can accept a job.
- req_n  in  4  operand n.
- resp_valid  out  1  response valid.
- resp_ready  in  1  host accepts response.
- resp_result  out  32  n!; 0 when resp_err or resp_timeout is set.
- resp_err  out  1  peripheral reported err.
- resp_timeout  out  1  TIMEOUT_CYC expired.
- busy  out  1  any state other than IDLE.
- bus_a  out  2  register address.
- bus_we  out  1  write enable.
- bus_wd  out  4  write data.
- bus_rd  in  32  read data, combinational from bus_a in the same cycle.

Behaviour:
- One clock domain (clk), asynchronous active-low reset (rst_n). All outputs come from registers.
- Register map:
  - 0 = N (W, wd[3:0]).
  - 1 = GO (W; writing bit0=1 starts a job and clears STATUS).
  - 2 = STATUS (R; bit0 done, bit1 err).
  - 3 = RESULT (R).
- Reset state: state IDLE, req_ready=1, resp_valid=0, resp_result=0, resp_err=0, resp_timeout=0, busy=0, bus_we=0, bus_a=0, bus_wd=0, all counters 0.
- Bus rules:
  - A write commits at the rising edge where bus_we=1.
  - A read samples bus_rd at the end of the cycle in which bus_a is presented with bus_we=0.
  - At most one transaction per cycle; bus_we is high for exactly one cycle per write.
- FSM:
  - IDLE: req_ready=1. On req_valid, latch req_n and go to WR_N. The request handshake occurs at this edge.
  - WR_N: a=0, we=1, wd=latched n. Go to WR_GO.
  - WR_GO: a=1, we=1, wd=4'b0001. Clear the timeout counter, load the settle counter with SETTLE, go to WAIT.
  - WAIT: we=0. Decrement the wait counter; at 0 go to POLL.
  - POLL: a=2, we=0.
    - If bus_rd[1]=1: set err, result 0, go to RESP. err takes priority over done.
    - Else if bus_rd[0]=1: go to RD_RES.
    - Else: load the wait counter with POLL_GAP and go to WAIT, or stay in POLL if POLL_GAP=0.
  - RD_RES: a=3, we=0. Capture bus_rd into resp_result, go to RESP.
  - RESP: resp_valid=1. Hold resp_result, resp_err and resp_timeout stable until resp_valid and resp_ready are both high. Then clear resp_valid and go to IDLE.
- Timeout:
  - The counter increments every cycle in WAIT and POLL.
  - Reaching TIMEOUT_CYC-1 forces RESP with resp_timeout=1 and result 0.
  - If the timeout and a done/err observation occur in the same cycle, the observation wins.
- SETTLE ≥2 is mandatory. The peripheral's done flag can re-assert from the previous job for one cycle after GO. Polling earlier returns stale results.
- Latency:
  - Request accept to first GO commit: 2 cycles.
  - Done-visible to resp_valid: 2 cycles (POLL, then RD_RES).
- New requests are not accepted while busy; req_ready=0 outside IDLE.
- Response back-pressure: the FSM stalls in RESP indefinitely; no bus activity occurs.
- Reset mid-operation: everything returns to the reset state immediately. Any in-flight peripheral job is abandoned; the next GO write restarts it.
- Width rules: req_n passes through unmodified (0..15). Overflow detection for n>12 is the peripheral's job, reported via err.

Decomposition:
- fact_pkg:
  - Address localparams: FACT_A_N=0, FACT_A_GO=1, FACT_A_STATUS=2, FACT_A_RESULT=3.
  - Status bit indices: DONE_BIT=0, ERR_BIT=1.
  - FSM state enum: IDLE, WR_N, WR_GO, WAIT, POLL, RD_RES, RESP.
- One sub-module: fact_poll_timer. It holds the loadable down-counter (settle/poll gap) and the timeout up-counter with its expiry flag.

Test Plan:
- n=5 against the real fact_top → bus trace shows N=5 write, then GO=1 write, then polls. Response: result=120, err=0, timeout=0.
- n=0 and n=12 back-to-back → responses 1 and 479001600 in order. req_ready is low during each job. No stale done is accepted for the second job.
- n=13 → resp_err=1, resp_result=0, and no RESULT read issued.
- Stub slave that never sets done, TIMEOUT_CYC=16 → resp_timeout=1 exactly 16 cycles after the GO commit; result=0.
- resp_ready held low 20 cycles after n=3 → resp_valid and result=6 held stable, no bus transactions. Then accepted, returns to IDLE.
- rst_n asserted during POLL, then a new request n=4 → all outputs at reset values asynchronously. The second job returns 24.
